// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares the single-port MIPS data memory between the CPU
// load/store port (A, fixed priority) and a read-only scan engine (B).
// Port B gets a forced slot after MAX_WAIT consecutive denials, which stalls
// the CPU for that cycle. Read data returns one cycle after service, routed
// by a small owner register.
//
// The only state is the wait counter and the read-return owner register, so
// there is no state table. Owner encoding:
//   owner    | meaning
//   OWN_NONE | nothing returns next cycle (idle, store, or reset)
//   OWN_A    | CPU load returns next cycle
//   OWN_B    | scan-engine read returns next cycle
module mips_mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        A_Req,
  input  logic [31:0] A_Addr,
  input  logic        A_Write,
  input  logic        A_HalfW,
  input  logic [31:0] A_WData,
  output logic        A_Stall,
  output logic        A_RValid,
  output logic [31:0] A_RData,
  input  logic        B_Req,
  input  logic [31:0] B_Addr,
  output logic        B_Gnt,
  output logic        B_RValid,
  output logic [31:0] B_RData,
  output logic [31:0] Mem_Addr,
  output logic        Mem_Write,
  output logic        Mem_HalfW,
  output logic [31:0] Mem_WData,
  input  logic [31:0] Mem_RData
);

  // The full 32-bit address is forwarded; ADDR_W only documents which bits
  // the memory decodes, so it is range-checked here and not used otherwise.
  if (ADDR_W < 1 || ADDR_W > 30) begin : g_bad_addr_w
    $error("mips_mem_arbiter: ADDR_W out of range");
  end
  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("mips_mem_arbiter: MAX_WAIT must be 1..15");
  end

  localparam logic [3:0] C_MAX = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_A    = 2'b01,
    OWN_B    = 2'b10
  } owner_t;

  logic [3:0]  r_wcnt;
  owner_t      r_owner;
  logic        r_half;
  logic        r_addr1;
  logic [31:0] r_mem_addr;
  logic [31:0] r_a_rdata;
  logic [31:0] r_b_rdata;

  logic        w_force;
  logic        w_sel_a;
  logic        w_sel_b;
  logic [3:0]  w_wcnt_nxt;
  owner_t      w_owner_nxt;
  logic [31:0] w_a_ret;

  // Grant: CPU first, unless B has waited MAX_WAIT cycles or A is idle.
  always_comb begin
    w_force = B_Req && (r_wcnt == C_MAX);
    w_sel_b = B_Req && (!A_Req || w_force);
    w_sel_a = A_Req && !w_sel_b;
    A_Stall = A_Req && w_sel_b;
    B_Gnt   = w_sel_b;
  end

  // Memory-side mux; idle keeps the last address so the memory sees no toggle.
  always_comb begin
    Mem_Addr  = r_mem_addr;
    Mem_Write = 1'b0;
    Mem_HalfW = 1'b0;
    Mem_WData = 32'h0;
    if (w_sel_a) begin
      Mem_Addr  = A_Addr;
      Mem_Write = A_Write && !RST;
      Mem_HalfW = A_HalfW;
      Mem_WData = A_WData;
    end else if (w_sel_b) begin
      Mem_Addr = B_Addr;
    end
  end

  // Next wait count and next read-return owner.
  always_comb begin
    w_wcnt_nxt = 4'd0;
    if (B_Req && !w_sel_b) begin
      w_wcnt_nxt = (r_wcnt == C_MAX) ? r_wcnt : r_wcnt + 4'd1;
    end
    w_owner_nxt = OWN_NONE;
    if (w_sel_b) begin
      w_owner_nxt = OWN_B;
    end else if (w_sel_a && !A_Write) begin
      w_owner_nxt = OWN_A;
    end
  end

  // CPU return data: halfword loads are zero-extended from the addressed half.
  always_comb begin
    w_a_ret = Mem_RData;
    if (r_half) begin
      w_a_ret = r_addr1 ? {16'h0, Mem_RData[31:16]} : {16'h0, Mem_RData[15:0]};
    end
  end

  // Arbitration state, return tracking and held read data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wcnt     <= 4'd0;
      r_owner    <= OWN_NONE;
      r_half     <= 1'b0;
      r_addr1    <= 1'b0;
      r_mem_addr <= 32'h0;
      r_a_rdata  <= 32'h0;
      r_b_rdata  <= 32'h0;
    end else begin
      r_wcnt     <= w_wcnt_nxt;
      r_owner    <= w_owner_nxt;
      r_half     <= w_sel_a && A_HalfW;
      r_addr1    <= w_sel_a && A_Addr[1];
      r_mem_addr <= Mem_Addr;
      if (r_owner == OWN_A) begin
        r_a_rdata <= w_a_ret;
      end
      if (r_owner == OWN_B) begin
        r_b_rdata <= Mem_RData;
      end
    end
  end

  // Return outputs: live data on the valid cycle, held value otherwise;
  // reset suppresses any return still in flight.
  always_comb begin
    A_RValid = (r_owner == OWN_A) && !RST;
    B_RValid = (r_owner == OWN_B) && !RST;
    A_RData  = r_a_rdata;
    B_RData  = r_b_rdata;
    if (RST) begin
      A_RData = 32'h0;
      B_RData = 32'h0;
    end else begin
      if (A_RValid) A_RData = w_a_ret;
      if (B_RValid) B_RData = Mem_RData;
    end
  end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares the single-port MIPS data memory (word-addressed, 16-bit upper/lower halves, synchronous read) between two requesters.
  - Port A: CPU load/store, read/write, word or halfword.
  - Port B: display/scan engine, read-only, word.
- CPU has fixed priority. A starvation counter forces a Port B slot after MAX_WAIT consecutive denials and stalls the CPU for that cycle.
- Sits between the CPU memory stage and the data-memory block. Drives that block's address, write-enable, halfword-select and write-data inputs.

Parameters:
- ADDR_W, 10, word-address width forwarded to memory (byte address bits [ADDR_W+1:2]).
- MAX_WAIT, 4, consecutive cycles Port B may be denied before a forced grant (1..15).

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- A_Req  in  1  CPU access request this cycle
- A_Addr  in  32  CPU byte address
- A_Write  in  1  1 = store, 0 = load
- A_HalfW  in  1  1 = halfword access, 0 = word
- A_WData  in  32  store data (halfword in [15:0])
- A_Stall  out  1  CPU request not served this cycle; CPU must hold all A_* inputs
- A_RValid  out  1  load data valid (one cycle after service)
- A_RData  out  32  load data
- B_Req  in  1  scan engine read request
- B_Addr  in  32  scan engine byte address (word aligned)
- B_Gnt  out  1  B request served this cycle
- B_RValid  out  1  B read data valid (one cycle after grant)
- B_RData  out  32  B read data
- Mem_Addr  out  32  address to data memory
- Mem_Write  out  1  write enable to data memory
- Mem_HalfW  out  1  halfword select to data memory
- Mem_WData  out  32  write data to data memory
- Mem_RData  in  32  synchronous read data from memory (valid the cycle after address)

Behaviour:
- Grant logic is combinational from the inputs and the wait counter (wcnt, 4 bits).
  - force = B_Req && (wcnt == MAX_WAIT).
  - Port B is selected if B_Req && (!A_Req || force).
  - Otherwise Port A is selected if A_Req.
  - Otherwise idle.
- A_Stall = A_Req && B selected. B_Gnt = B selected.
- Mem_* outputs:
  - Port A selected: Mem_* = A fields, Mem_Write = A_Write.
  - Port B selected: Mem_Addr = B_Addr, Mem_Write = 0, Mem_HalfW = 0, Mem_WData = 0.
  - Idle: Mem_Write = 0, Mem_Addr holds the last registered value, Mem_WData = 0.
- Wait counter, updated each cycle:
  - If B_Req && !B_Gnt: wcnt increments, saturating at MAX_WAIT.
  - Otherwise: wcnt = 0.
  - A forced grant therefore occurs on the (MAX_WAIT+1)th cycle of continuous B_Req under continuous A_Req.
- Read return pipeline:
  - Registers capture owner (A-load / B / none), halfword flag and addr[1] at each service.
  - Next cycle, owner A-load: A_RValid = 1.
    - A_RData = Mem_RData for a word load.
    - A_RData = zero-extended Mem_RData[31:16] if addr[1] = 1, else Mem_RData[15:0], for a halfword load.
  - Next cycle, owner B: B_RValid = 1, B_RData = Mem_RData.
  - Stores produce no RValid.
- Read latency: 1 cycle from service to RValid. Back-to-back services are allowed every cycle with no bubble. RData is held until the next RValid.
- Simultaneous A_Req and B_Req with wcnt < MAX_WAIT: A wins, wcnt increments.
- A_Req de-asserted while B waiting: B granted that cycle, wcnt cleared.
- Address bits above ADDR_W+1 pass through unchanged; memory decoding is not the arbiter's concern.
- Reset behaviour:
  - RST = 1 clears wcnt, owner = none, A_RValid = B_RValid = 0, A_RData = B_RData = 0, registered Mem_Addr = 0.
  - While RST is high, combinational outputs still follow the grant rule, but Mem_Write is forced to 0.
  - Reset mid-access drops any pending RValid.
- No state machine beyond wcnt and the owner register. Owner register encoding: 2'b00 none, 2'b01 A-load, 2'b10 B.

Test Plan:
- Reset: RST = 1 for 2 cycles with A_Req = 1, A_Write = 1 -> Mem_Write = 0, A_RValid = B_RValid = 0, wcnt = 0 after release.
- CPU word store then load: A store addr 0x10, data 0xDEADBEEF, then load 0x10 -> Mem_Write pulses 1 cycle, next cycle A_RValid = 1, A_RData = 0xDEADBEEF.
- Halfword load: memory word 0x12345678 at 0x20; A_HalfW = 1 at 0x22 -> A_RData = 0x00001234; at 0x20 -> 0x00005678.
- Contention: A_Req and B_Req held high continuously, MAX_WAIT = 4 -> A served cycles 0-3, B_Gnt = 1 and A_Stall = 1 on cycle 4, pattern repeats with period 5.
- Idle A: B_Req = 1 addr 0x40, A_Req = 0 -> B_Gnt = 1 same cycle, B_RValid = 1 next cycle with B_RData = memory word at 0x40, wcnt stays 0.
- Reset mid-access: B granted, RST asserted the following cycle -> B_RValid = 0, wcnt = 0, no stale RData presented.
